aes_key_schedule: RTL and testbench

- Parametrised word-serial AES key schedule covering AES-128, AES-192 and AES-256, with the key length selected at load time.
- Expands the cipher key one 32-bit word per cycle into an internal round-key buffer of 4*(Nr+1) words.
- Serves any 128-bit round key on request with a fixed one-cycle latency.
- Sits between the key-load path and the round datapath in the core.

---
 rtl/aes_key_schedule.sv | 204 ++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key schedule with a registered one-cycle round-key read port.
// Optional macro KS_EQINV_EN adds rk_inv_in for equivalent-inverse-cipher (InvMixColumns) round keys.
module aes_key_schedule #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_NK     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   key_mode_in,
   input  logic [MAX_NK*DATA_WIDTH-1:0] key_in,
   input  logic                         key_valid_in,
   output logic                         key_ready_out,
   input  logic                         rk_req_in,
   input  logic [3:0]                   rk_round_in,
`ifdef KS_EQINV_EN
   input  logic                         rk_inv_in,
`endif
   output logic                         rk_valid_out,
   output logic [4*DATA_WIDTH-1:0]      rk_data_out,
   output logic                         busy_out,
   output logic                         done_out,
   output logic                         err_out
);

   localparam int DEPTH = 4 * (MAX_NK + 7);
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t                  state, next_state;
   logic [DATA_WIDTH-1:0]   buffer [DEPTH];
   logic [AW-1:0]           exp_idx, last_idx, mode_total, rd_base;
   logic [2:0]              j_cnt, j_last;
   logic [7:0]              rcon;
   logic [3:0]              nk, nr, mode_nk, mode_nr;
   logic                    mode_bad, accept;
   logic [DATA_WIDTH-1:0]   prev_word, sub_in, sub_out, temp, new_word;
   logic [4*DATA_WIDTH-1:0] rd_key;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254 by an addition chain) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] a2, a3, a12, a15, a240, inv;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
      a15  = gf_mul(a12, a3);
      a240 = gf_mul(a15, a15);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      inv  = gf_mul(gf_mul(a240, a12), a2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

`ifdef KS_EQINV_EN
   function automatic logic [31:0] inv_mix(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction
`endif

   always_comb begin
      mode_nk    = 4'd0;
      mode_nr    = 4'd0;
      mode_total = '0;
      case (key_mode_in)
         2'b00:   begin mode_nk = 4'd4; mode_nr = 4'd10; mode_total = AW'(44); end
         2'b01:   begin mode_nk = 4'd6; mode_nr = 4'd12; mode_total = AW'(52); end
         2'b10:   begin mode_nk = 4'd8; mode_nr = 4'd14; mode_total = AW'(60); end
         default: begin mode_nk = 4'd0; mode_nr = 4'd0;  mode_total = '0;      end
      endcase
      mode_bad = (key_mode_in == 2'b11) || (int'(mode_nk) > MAX_NK);
      accept   = key_valid_in && key_ready_out;
   end

   // One SubWord instance serves both the rotated (j==0) and the AES-256 j==4 case.
   always_comb begin
      j_last    = 3'(nk - 4'd1);
      prev_word = buffer[exp_idx - AW'(1)];
      sub_in    = (j_cnt == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
      sub_out   = sub_word(sub_in);
      temp      = prev_word;
      if (j_cnt == 3'd0)
         temp = sub_out ^ {rcon, 24'h000000};
      else if (nk == 4'd8 && j_cnt == 3'd4)
         temp = sub_out;
      new_word  = buffer[exp_idx - AW'(nk)] ^ temp;
   end

   always_comb begin
      rd_base = AW'({rk_round_in, 2'b00});
      rd_key  = {buffer[rd_base], buffer[rd_base + AW'(1)],
                 buffer[rd_base + AW'(2)], buffer[rd_base + AW'(3)]};
`ifdef KS_EQINV_EN
      if (rk_inv_in && rk_round_in >= 4'd1 && rk_round_in < nr)
         rd_key = {inv_mix(rd_key[127:96]), inv_mix(rd_key[95:64]),
                   inv_mix(rd_key[63:32]), inv_mix(rd_key[31:0])};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (accept)
         next_state = mode_bad ? IDLE : EXPAND;
      else if (state == EXPAND && exp_idx == last_idx)
         next_state = READY;
   end

   always_comb begin
      key_ready_out = (state != EXPAND) && !rst;
      busy_out      = (state == EXPAND);
      done_out      = (state == READY);
   end

   // The buffer needs no reset; a read always follows a complete expansion.
   always_ff @(posedge clk) begin
      if (accept && !mode_bad) begin
         for (int k = 0; k < MAX_NK; k++)
            if (k < int'(mode_nk))
               buffer[k] <= key_in[(MAX_NK-1-k)*DATA_WIDTH +: DATA_WIDTH];
      end else if (state == EXPAND) begin
         buffer[exp_idx] <= new_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_idx      <= '0;
         last_idx     <= '0;
         j_cnt        <= 3'd0;
         rcon         <= 8'h00;
         nk           <= 4'd0;
         nr           <= 4'd0;
         rk_valid_out <= 1'b0;
         rk_data_out  <= '0;
         err_out      <= 1'b0;
      end else begin
         rk_valid_out <= 1'b0;
         err_out      <= 1'b0;
         if (accept) begin
            if (mode_bad) begin
               err_out <= 1'b1;
            end else begin
               nk       <= mode_nk;
               nr       <= mode_nr;
               last_idx <= mode_total - AW'(1);
               exp_idx  <= AW'(mode_nk);
               j_cnt    <= 3'd0;
               rcon     <= 8'h01;
            end
         end else if (state == EXPAND) begin
            exp_idx <= exp_idx + AW'(1);
            if (j_cnt == j_last) begin
               j_cnt <= 3'd0;
               rcon  <= xtime(rcon);
            end else begin
               j_cnt <= j_cnt + 3'd1;
            end
         end
         if (rk_req_in) begin
            if (state != READY) begin
               err_out <= 1'b1;
            end else if (rk_round_in > nr) begin
               rk_valid_out <= 1'b1;
               rk_data_out  <= '0;
               err_out      <= 1'b1;
            end else begin
               rk_valid_out <= 1'b1;
               rk_data_out  <= rd_key;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 key-expansion vectors.
// Inputs are driven and outputs sampled on the falling edge.
module tb_aes_key_schedule;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   key_mode_in;
   logic [255:0] key_in;
   logic         key_valid_in;
   logic         key_ready_out;
   logic         rk_req_in;
   logic [3:0]   rk_round_in;
   logic         rk_valid_out;
   logic [127:0] rk_data_out;
   logic         busy_out;
   logic         done_out;
   logic         err_out;
`ifdef KS_EQINV_EN
   logic         rk_inv_in;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] KEY128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] RK128_10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [191:0] KEY192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
   localparam logic [127:0] RK192_12 = 128'he98ba06f_448c773c_8ecc7204_01002202;
   localparam logic [255:0] KEY256 =
      256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
   localparam logic [127:0] RK256_14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

   always #5 clk = ~clk;

   aes_key_schedule #(.DATA_WIDTH(32), .MAX_NK(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_mode_in  (key_mode_in),
      .key_in       (key_in),
      .key_valid_in (key_valid_in),
      .key_ready_out(key_ready_out),
      .rk_req_in    (rk_req_in),
      .rk_round_in  (rk_round_in),
`ifdef KS_EQINV_EN
      .rk_inv_in    (rk_inv_in),
`endif
      .rk_valid_out (rk_valid_out),
      .rk_data_out  (rk_data_out),
      .busy_out     (busy_out),
      .done_out     (done_out),
      .err_out      (err_out)
   );

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Offers a key for one cycle; returns on the falling edge after the accepting edge.
   task automatic applyStimulus(input logic [1:0] mode, input logic [255:0] key);
      @(negedge clk);
      key_mode_in  = mode;
      key_in       = key;
      key_valid_in = 1'b1;
      @(negedge clk);
      key_valid_in = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int exp_cycles);
      int n = 0;
      while (busy_out && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_busy_cycles"}, 128'(n), 128'(exp_cycles));
      checkOutput({tag, "_done"}, 128'(done_out), 128'd1);
   endtask

   task automatic readRound(input logic [3:0] r, input logic inv);
      @(negedge clk);
      rk_req_in   = 1'b1;
      rk_round_in = r;
`ifdef KS_EQINV_EN
      rk_inv_in   = inv;
`endif
      @(negedge clk);
      rk_req_in   = 1'b0;
`ifdef KS_EQINV_EN
      rk_inv_in   = 1'b0;
`endif
      if (inv) begin end
   endtask

   task automatic checkRead(input string tag, input logic [127:0] data, input logic err);
      checkOutput({tag, "_valid"}, 128'(rk_valid_out), 128'd1);
      checkOutput({tag, "_data"}, rk_data_out, data);
      checkOutput({tag, "_err"}, 128'(err_out), 128'(err));
   endtask

`ifdef KS_EQINV_EN
   function automatic logic [7:0] mulModel(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] invMixModel(input logic [31:0] c);
      logic [7:0] b [4];
      logic [7:0] o [4];
      logic [7:0] m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int k = 0; k < 4; k++) b[k] = c[31-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
         o[r] = 8'h00;
         for (int k = 0; k < 4; k++) o[r] ^= mulModel(b[k], m[(k - r + 4) % 4]);
      end
      return {o[0], o[1], o[2], o[3]};
   endfunction
`endif

   initial begin
      logic [127:0] held;
      rst          = 1'b1;
      key_mode_in  = 2'b00;
      key_in       = '0;
      key_valid_in = 1'b0;
      rk_req_in    = 1'b0;
      rk_round_in  = 4'd0;
`ifdef KS_EQINV_EN
      rk_inv_in    = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 128'(key_ready_out), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_valid", 128'(rk_valid_out), 128'd0);
      checkOutput("rst_data", rk_data_out, 128'd0);
      checkOutput("rst_busy", 128'(busy_out), 128'd0);
      checkOutput("rst_done", 128'(done_out), 128'd0);
      checkOutput("rst_err", 128'(err_out), 128'd0);
      checkOutput("idle_ready", 128'(key_ready_out), 128'd1);

      $display("[TB] AES-128 expansion");
      applyStimulus(2'b00, {KEY128, 128'hffffffff_00000000_12345678_9abcdef0});
      checkOutput("k128_ready_low", 128'(key_ready_out), 128'd0);
      waitDone("k128", 40);
      readRound(4'd10, 1'b0);
      checkRead("k128_r10", RK128_10, 1'b0);
      readRound(4'd0, 1'b0);
      checkRead("k128_r0", KEY128, 1'b0);
      readRound(4'd11, 1'b0);
      checkRead("k128_r11", 128'd0, 1'b1);
      @(negedge clk);
      checkOutput("valid_pulse", 128'(rk_valid_out), 128'd0);

      $display("[TB] reserved mode");
      applyStimulus(2'b11, {KEY128, 128'd0});
      checkOutput("mode11_err", 128'(err_out), 128'd1);
      checkOutput("mode11_ready", 128'(key_ready_out), 128'd1);
      checkOutput("mode11_done", 128'(done_out), 128'd0);
      checkOutput("mode11_busy", 128'(busy_out), 128'd0);

      $display("[TB] AES-192 expansion");
      applyStimulus(2'b01, {KEY192, 64'hdeadbeef_cafef00d});
      waitDone("k192", 46);
      readRound(4'd12, 1'b0);
      checkRead("k192_r12", RK192_12, 1'b0);

      $display("[TB] AES-256 expansion");
      applyStimulus(2'b10, KEY256);
      waitDone("k256", 52);
      readRound(4'd14, 1'b0);
      checkRead("k256_r14", RK256_14, 1'b0);
      readRound(4'd0, 1'b0);
      checkRead("k256_r0", KEY256[255:128], 1'b0);
      held = KEY256[255:128];

      $display("[TB] read during expansion, then reset mid-expansion");
      applyStimulus(2'b00, {KEY128, 128'd0});
      repeat (4) @(negedge clk);
      readRound(4'd3, 1'b0);
      checkOutput("exp_read_err", 128'(err_out), 128'd1);
      checkOutput("exp_read_valid", 128'(rk_valid_out), 128'd0);
      checkOutput("exp_read_hold", rk_data_out, held);
      repeat (13) @(negedge clk);
      checkOutput("exp_busy", 128'(busy_out), 128'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_ready", 128'(key_ready_out), 128'd0);
      checkOutput("mid_rst_busy", 128'(busy_out), 128'd0);
      checkOutput("mid_rst_done", 128'(done_out), 128'd0);
      checkOutput("mid_rst_data", rk_data_out, 128'd0);
      checkOutput("mid_rst_valid", 128'(rk_valid_out), 128'd0);
      checkOutput("mid_rst_err", 128'(err_out), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", 128'(key_ready_out), 128'd1);
      applyStimulus(2'b00, {KEY128, 128'd0});
      waitDone("k128b", 40);
      readRound(4'd10, 1'b0);
      checkRead("k128b_r10", RK128_10, 1'b0);
`ifdef KS_EQINV_EN
      readRound(4'd5, 1'b1);
      checkRead("inv_r5", {invMixModel(32'hd4d1c6f8), invMixModel(32'h7c839d87),
                           invMixModel(32'hcaf2b8bc), invMixModel(32'h11f915bc)}, 1'b0);
      readRound(4'd10, 1'b1);
      checkRead("inv_r10", RK128_10, 1'b0);
`endif

      $display("[TB] concurrent read and reload");
      @(negedge clk);
      rk_req_in    = 1'b1;
      rk_round_in  = 4'd10;
      key_mode_in  = 2'b10;
      key_in       = KEY256;
      key_valid_in = 1'b1;
      @(negedge clk);
      rk_req_in    = 1'b0;
      key_valid_in = 1'b0;
      checkRead("conc_old_r10", RK128_10, 1'b0);
      checkOutput("conc_busy", 128'(busy_out), 128'd1);
      checkOutput("conc_done", 128'(done_out), 128'd0);
      waitDone("conc", 52);
      readRound(4'd14, 1'b0);
      checkRead("conc_new_r14", RK256_14, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
